// File: rtl/ysyx_24080006_sram.sv
// rtl/ysyx_24080006_sram.sv - AXI4-Lite word-addressed SRAM responder with programmable access latency
// Independent read/write FSMs; one outstanding transaction per direction.
module ysyx_24080006_sram #(
  parameter logic [31:0] BASE       = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 16,
  parameter int          LATENCY    = 2
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        awvalid_i,
  output logic        awready_o,
  input  logic [31:0] awaddr_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  output logic        bvalid_o,
  input  logic        bready_i,
  output logic [1:0]  bresp_o,
  input  logic        arvalid_i,
  output logic        arready_o,
  input  logic [31:0] araddr_i,
  output logic        rvalid_o,
  input  logic        rready_i,
  output logic [31:0] rdata_o,
  output logic [1:0]  rresp_o
);

  localparam logic [63:0] SPAN   = 64'd4 << DEPTH_LOG2;
  localparam logic [3:0]  LAT    = 4'(LATENCY);
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_COLLECT, W_WAIT, W_RESP} wstate_t;

  function automatic logic in_range(input logic [31:0] a);
    return (a >= BASE) && ({32'b0, a - BASE} < SPAN);
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return DEPTH_LOG2'(off >> 2);
  endfunction

  logic [31:0] mem_q [0:(1<<DEPTH_LOG2)-1];

  rstate_t     rstate_q;
  logic [3:0]  rcnt_q;
  logic [31:0] raddr_q;
  logic        arready_q, rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  wstate_t     wstate_q;
  logic [3:0]  wcnt_q;
  logic [31:0] waddr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        awready_q, wready_q, bvalid_q;
  logic [1:0]  bresp_q;

  logic aw_hs, w_hs, mem_we;
  assign aw_hs  = awvalid_i && awready_q;
  assign w_hs   = wvalid_i && wready_q;
  assign mem_we = !reset_i && (wstate_q == W_WAIT) && (wcnt_q == 4'd0) && in_range(waddr_q);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rstate_q  <= R_IDLE;
      rcnt_q    <= 4'd0;
      raddr_q   <= 32'd0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
      rresp_q   <= OKAY;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (arvalid_i && arready_q) begin
            raddr_q   <= araddr_i;
            rcnt_q    <= LAT;
            arready_q <= 1'b0;
            rstate_q  <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (rcnt_q == 4'd0) begin
            rstate_q <= R_RESP;
            rvalid_q <= 1'b1;
            if (in_range(raddr_q)) begin
              rdata_q <= mem_q[word_idx(raddr_q)];
              rresp_q <= OKAY;
            end else begin
              rdata_q <= 32'd0;
              rresp_q <= DECERR;
            end
          end else begin
            rcnt_q <= rcnt_q - 4'd1;
          end
        end
        R_RESP: begin
          if (rready_i) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rstate_q  <= R_IDLE;
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wstate_q  <= W_IDLE;
      wcnt_q    <= 4'd0;
      waddr_q   <= 32'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
    end else begin
      if (aw_hs) waddr_q <= awaddr_i;
      if (w_hs) begin
        wdata_q <= wdata_i;
        wstrb_q <= wstrb_i;
      end
      case (wstate_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          wready_q  <= 1'b1;
          if (aw_hs && w_hs) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            wcnt_q    <= LAT;
            wstate_q  <= W_WAIT;
          end else if (aw_hs || w_hs) begin
            awready_q <= !aw_hs;
            wready_q  <= !w_hs;
            wstate_q  <= W_COLLECT;
          end
        end
        // Only the still-missing channel is ready here, so any handshake completes the pair.
        W_COLLECT: begin
          if (aw_hs || w_hs) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            wcnt_q    <= LAT;
            wstate_q  <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (wcnt_q == 4'd0) begin
            bvalid_q <= 1'b1;
            bresp_q  <= in_range(waddr_q) ? OKAY : DECERR;
            wstate_q <= W_RESP;
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        W_RESP: begin
          if (bready_i) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            wstate_q  <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  // Storage has no reset so contents survive a reset pulse.
  always_ff @(posedge clock_i) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem_q[word_idx(waddr_q)][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign awready_o = awready_q;
  assign wready_o  = wready_q;
  assign bvalid_o  = bvalid_q;
  assign bresp_o   = bresp_q;
  assign arready_o = arready_q;
  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rdata_q;
  assign rresp_o   = rresp_q;

endmodule

// File: tb/tb_ysyx_24080006_sram.sv
// tb/tb_ysyx_24080006_sram.sv - bench for the AXI4-Lite SRAM responder
// Table vectors, hand sequences for reset/backpressure/collision, then random traffic vs a byte-level model.
module tb_ysyx_24080006_sram;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int DL  = 16;
  localparam int LAT = 2;

  logic clk = 1'b0, rst = 1'b1;
  logic awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
  logic arvalid = 0, arready, rvalid, rready = 0;
  logic [31:0] awaddr = 0, wdata = 0, araddr = 0, rdata;
  logic [3:0] wstrb = 0;
  logic [1:0] bresp, rresp;

  int total = 0, passed = 0;
  logic [7:0] mem_m [bit [31:0]];

  always #5 clk = ~clk;

  ysyx_24080006_sram #(.BASE(BASE), .DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
    .clock_i(clk), .reset_i(rst),
    .awvalid_i(awvalid), .awready_o(awready), .awaddr_i(awaddr),
    .wvalid_i(wvalid), .wready_o(wready), .wdata_i(wdata), .wstrb_i(wstrb),
    .bvalid_o(bvalid), .bready_i(bready), .bresp_o(bresp),
    .arvalid_i(arvalid), .arready_o(arready), .araddr_i(araddr),
    .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata), .rresp_o(rresp)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    longint unsigned lo, hi;
    lo = longint'(BASE);
    hi = lo + 4 * (longint'(1) << DL);
    return (longint'(a) >= lo) && (longint'(a) < hi);
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit [31:0] w;
    if (!in_rng(a)) return;
    w = {a[31:2], 2'b00};
    for (int i = 0; i < 4; i++) if (s[i]) mem_m[w + i] = d[8*i +: 8];
  endfunction

  function automatic void model_read(input logic [31:0] a, output logic [31:0] d,
                                     output logic [31:0] m, output logic [1:0] r);
    bit [31:0] w;
    d = 0; m = 0;
    if (!in_rng(a)) begin m = 32'hFFFF_FFFF; r = 2'b11; return; end
    r = 2'b00;
    w = {a[31:2], 2'b00};
    for (int i = 0; i < 4; i++)
      if (mem_m.exists(w + i)) begin d[8*i +: 8] = mem_m[w + i]; m[8*i +: 8] = 8'hFF; end
  endfunction

  // lead > 0: W precedes AW by lead cycles; lead < 0: AW precedes W.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead, output logic [1:0] resp, output int lat);
    int cyc = 0, aw_start, w_start;
    bit aw_done = 0, w_done = 0, hs_aw, hs_w;
    aw_start = (lead > 0) ? lead : 0;
    w_start  = (lead < 0) ? -lead : 0;
    while (!(aw_done && w_done) && cyc < 60) begin
      if (cyc == aw_start && !aw_done) begin awvalid = 1; awaddr = a; end
      if (cyc == w_start && !w_done) begin wvalid = 1; wdata = d; wstrb = s; end
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      @(posedge clk); #1; cyc++;
      if (hs_aw) begin aw_done = 1; awvalid = 0; end
      if (hs_w) begin w_done = 1; wvalid = 0; end
      if (aw_done ^ w_done) begin
        chk("collect_awready", awready, aw_done ? 0 : 1);
        chk("collect_wready", wready, w_done ? 0 : 1);
      end
    end
    chk("aw_w_handshake", aw_done && w_done, 1);
    lat = 0;
    while (!bvalid && lat < 60) begin @(posedge clk); #1; lat++; end
    resp = bresp;
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    chk("b_drop", bvalid, 0);
  endtask

  task automatic axi_read(input logic [31:0] a, input int hold, output logic [31:0] d,
                          output logic [1:0] resp, output int lat);
    int cyc = 0;
    bit hs = 0;
    arvalid = 1; araddr = a;
    while (!hs && cyc < 60) begin
      hs = arvalid && arready;
      @(posedge clk); #1; cyc++;
    end
    arvalid = 0;
    chk("ar_handshake", hs, 1);
    lat = 0;
    while (!rvalid && lat < 60) begin @(posedge clk); #1; lat++; end
    d = rdata; resp = rresp;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("r_hold_valid", rvalid, 1);
      chk("r_hold_data", rdata, d);
      chk("r_hold_arready", arready, 0);
    end
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
    chk("r_drop", rvalid, 0);
    chk("arready_after_r", arready, 1);
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          lead;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  initial begin
    vec_t vt[$];
    logic [31:0] d, ed, em;
    logic [1:0] r, er;
    int lat;
    bit seen;

    vt.push_back('{1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF,  0, 32'h0,         2'b00});
    vt.push_back('{0, 32'h8000_0010, 32'h0,         4'h0,  0, 32'hDEAD_BEEF, 2'b00});
    vt.push_back('{1, 32'h8000_0020, 32'h1122_3344, 4'hF,  0, 32'h0,         2'b00});
    vt.push_back('{1, 32'h8000_0020, 32'hAABB_CCDD, 4'h5, -2, 32'h0,         2'b00});
    vt.push_back('{0, 32'h8000_0020, 32'h0,         4'h0,  0, 32'h11BB_33DD, 2'b00});
    vt.push_back('{1, 32'h8000_0024, 32'hCAFE_F00D, 4'hF,  1, 32'h0,         2'b00});
    vt.push_back('{1, 32'h8000_0024, 32'h1234_5678, 4'h0,  0, 32'h0,         2'b00});
    vt.push_back('{0, 32'h8000_0024, 32'h0,         4'h0,  0, 32'hCAFE_F00D, 2'b00});
    vt.push_back('{1, 32'h8000_0000, 32'h0A0B_0C0D, 4'hF,  0, 32'h0,         2'b00});
    vt.push_back('{1, 32'h8003_FFFC, 32'h55AA_55AA, 4'hF,  0, 32'h0,         2'b00});
    vt.push_back('{0, 32'h7FFF_FFFC, 32'h0,         4'h0,  0, 32'h0,         2'b11});
    vt.push_back('{0, 32'h8004_0000, 32'h0,         4'h0,  0, 32'h0,         2'b11});
    vt.push_back('{1, 32'h8004_0000, 32'hFFFF_FFFF, 4'hF,  0, 32'h0,         2'b11});
    vt.push_back('{1, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF,  0, 32'h0,         2'b11});
    vt.push_back('{0, 32'h8000_0000, 32'h0,         4'h0,  0, 32'h0A0B_0C0D, 2'b00});
    vt.push_back('{0, 32'h8003_FFFF, 32'h0,         4'h0,  0, 32'h55AA_55AA, 2'b00});
    vt.push_back('{1, 32'h8000_0026, 32'h0000_0000, 4'hC,  0, 32'h0,         2'b00});
    vt.push_back('{0, 32'h8000_0024, 32'h0,         4'h0,  0, 32'h0000_F00D, 2'b00});

    repeat (3) @(posedge clk);
    #1;
    chk("rst_arready", arready, 0);
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_bresp", bresp, 0);
    rst = 0;
    @(posedge clk); #1;
    chk("post_rst_readies", {arready, awready, wready}, 3'b111);

    foreach (vt[i]) begin
      if (vt[i].is_wr) begin
        axi_write(vt[i].addr, vt[i].data, vt[i].strb, vt[i].lead, r, lat);
        model_write(vt[i].addr, vt[i].data, vt[i].strb);
        chk($sformatf("vec%0d_bresp", i), r, vt[i].exp_resp);
        chk($sformatf("vec%0d_blat", i), lat, LAT + 1);
      end else begin
        axi_read(vt[i].addr, 0, d, r, lat);
        chk($sformatf("vec%0d_rdata", i), d, vt[i].exp_rdata);
        chk($sformatf("vec%0d_rresp", i), r, vt[i].exp_resp);
        chk($sformatf("vec%0d_rlat", i), lat, LAT + 1);
      end
    end

    axi_write(32'h8000_0040, 32'h600D_CAFE, 4'hF, 4, r, lat);
    model_write(32'h8000_0040, 32'h600D_CAFE, 4'hF);
    chk("wfirst_bresp", r, 2'b00);
    axi_read(32'h8000_0040, 5, d, r, lat);
    chk("backpressure_rdata", d, 32'h600D_CAFE);

    axi_write(32'h8000_0030, 32'h0102_0304, 4'hF, 0, r, lat);
    model_write(32'h8000_0030, 32'h0102_0304, 4'hF);
    fork
      begin
        logic [1:0] wr_r; int wl;
        axi_write(32'h8000_0030, 32'hF0F0_F0F0, 4'hF, 0, wr_r, wl);
      end
      begin
        logic [31:0] rd_d; logic [1:0] rd_r; int rl;
        axi_read(32'h8000_0030, 0, rd_d, rd_r, rl);
        chk("collide_pre_write", rd_d, 32'h0102_0304);
      end
    join
    model_write(32'h8000_0030, 32'hF0F0_F0F0, 4'hF);
    axi_read(32'h8000_0030, 0, d, r, lat);
    chk("collide_post_write", d, 32'hF0F0_F0F0);

    arvalid = 1; araddr = 32'h8000_0010;
    @(posedge clk); #1;
    arvalid = 0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    chk("rst_rd_arready", arready, 1);
    seen = rvalid;
    repeat (6) begin @(posedge clk); #1; seen |= rvalid; end
    chk("rst_rd_no_rvalid", seen, 0);

    awvalid = 1; awaddr = 32'h8000_0010;
    @(posedge clk); #1;
    awvalid = 0;
    chk("rst_wr_collect", {awready, wready}, 2'b01);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    chk("rst_wr_readies", {awready, wready}, 2'b11);
    seen = bvalid;
    repeat (6) begin @(posedge clk); #1; seen |= bvalid; end
    chk("rst_wr_no_bvalid", seen, 0);
    axi_read(32'h8000_0010, 0, d, r, lat);
    chk("rst_storage_kept", d, 32'hDEAD_BEEF);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a, wd;
      logic [3:0] s;
      int sel;
      sel = $urandom_range(0, 7);
      if (sel == 0) a = BASE - 4 * $urandom_range(1, 8);
      else if (sel == 1) a = BASE + 32'h0004_0000 + 4 * $urandom_range(0, 8);
      else a = BASE + 4 * $urandom_range(0, 63) + $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom;
        s = 4'($urandom_range(0, 15));
        axi_write(a, wd, s, $urandom_range(0, 6) - 3, r, lat);
        model_write(a, wd, s);
        model_read(a, ed, em, er);
        chk($sformatf("rnd%0d_bresp", n), r, er);
        chk($sformatf("rnd%0d_blat", n), lat, LAT + 1);
      end else begin
        axi_read(a, $urandom_range(0, 3), d, r, lat);
        model_read(a, ed, em, er);
        chk($sformatf("rnd%0d_rdata", n), d & em, ed);
        chk($sformatf("rnd%0d_rresp", n), r, er);
        chk($sformatf("rnd%0d_rlat", n), lat, LAT + 1);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
